// File: rtl/mfp_pkg.sv
// Shared MFP timer definitions: prescaler codes, channel indices and the
// code-to-terminal-count mapping used by the timer clock front end.
package mfp_pkg;

    localparam int unsigned NCH_TIMERS = 4;
    localparam int unsigned TMR_A = 0;
    localparam int unsigned TMR_B = 1;
    localparam int unsigned TMR_C = 2;
    localparam int unsigned TMR_D = 3;

    typedef logic [2:0] ps_code_t;

    localparam ps_code_t PS_CODE_STOP   = 3'd0;
    localparam ps_code_t PS_CODE_DIV4   = 3'd1;
    localparam ps_code_t PS_CODE_DIV10  = 3'd2;
    localparam ps_code_t PS_CODE_DIV16  = 3'd3;
    localparam ps_code_t PS_CODE_DIV50  = 3'd4;
    localparam ps_code_t PS_CODE_DIV64  = 3'd5;
    localparam ps_code_t PS_CODE_DIV100 = 3'd6;
    localparam ps_code_t PS_CODE_DIV200 = 3'd7;

    // Largest terminal count of any code; also the hard wrap point of every counter.
    localparam logic [7:0] PS_LIM_MAX = 8'd199;

    function automatic logic [7:0] ps_limit(input ps_code_t code);
        logic [7:0] lim;
        case (code)
            PS_CODE_DIV4:   lim = 8'd3;
            PS_CODE_DIV10:  lim = 8'd9;
            PS_CODE_DIV16:  lim = 8'd15;
            PS_CODE_DIV50:  lim = 8'd49;
            PS_CODE_DIV64:  lim = 8'd63;
            PS_CODE_DIV100: lim = 8'd99;
            PS_CODE_DIV200: lim = 8'd199;
            default:        lim = 8'd0;
        endcase
        return lim;
    endfunction

endpackage

// File: rtl/mfp_prescaler_chan.sv
// One timer channel prescaler: 8-bit counter that wraps at the code's terminal
// count (or 199) and flips its tick toggle on every wrap.
module mfp_prescaler_chan
    import mfp_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_i,
    input  ps_code_t code_i,
    output logic     tick_o
);

    logic [7:0] cnt_q, cnt_d;
    logic       tick_q, tick_d;
    logic [7:0] lim;

    assign lim = ps_limit(code_i);

    // The 199 check bounds the first period when a shrinking code leaves cnt above the new limit.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = tick_q;
        if (code_i == PS_CODE_STOP) begin
            cnt_d = 8'd0;
        end else if (cnt_q == lim || cnt_q == PS_LIM_MAX) begin
            cnt_d  = 8'd0;
            tick_d = ~tick_q;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= 8'd0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/mfp_prescaler_sched.sv
// Timer-clock front end for the MFP timers: per-channel prescalers in the XCLK
// domain, updated from the CPU domain through a toggle request/acknowledge handshake.
module mfp_prescaler_sched
    import mfp_pkg::*;
#(
    parameter int unsigned NCH     = NCH_TIMERS,
    parameter int unsigned SYNC_FF = 2
) (
    input  logic           XCLK_I,
    input  logic           RST,
    input  logic           CTRL_REQ,
    input  logic [1:0]     CTRL_CH,
    input  logic [2:0]     CTRL_PS,
    output logic           CTRL_ACK,
    output logic [NCH-1:0] TICK_O,
    output logic [NCH-1:0] PS_ACTIVE,
    output logic           BUSY
);

    logic [SYNC_FF-1:0] sync_q;
    logic               hist_q;
    logic               req_edge;

    logic               busy_q, busy_d;
    logic               ack_q, ack_d;
    logic [1:0]         cap_ch_q, cap_ch_d;
    ps_code_t           cap_ps_q, cap_ps_d;
    ps_code_t           code_q [NCH];
    ps_code_t           code_d [NCH];
    logic [NCH-1:0]     ps_active_q, ps_active_d;

    assign req_edge = sync_q[SYNC_FF-1] ^ hist_q;

    // Detect cycle captures and raises BUSY; the following edge applies and acknowledges.
    // Edges arriving while BUSY are protocol violations and are dropped.
    always_comb begin
        busy_d      = busy_q;
        ack_d       = ack_q;
        cap_ch_d    = cap_ch_q;
        cap_ps_d    = cap_ps_q;
        code_d      = code_q;
        ps_active_d = ps_active_q;
        if (busy_q) begin
            busy_d = 1'b0;
            ack_d  = ~ack_q;
            for (int ch = 0; ch < int'(NCH); ch++) begin
                if (int'(cap_ch_q) == ch) begin
                    code_d[ch] = cap_ps_q;
                end
            end
        end else if (req_edge) begin
            busy_d   = 1'b1;
            cap_ch_d = CTRL_CH;
            cap_ps_d = CTRL_PS;
        end
        for (int ch = 0; ch < int'(NCH); ch++) begin
            ps_active_d[ch] = (code_d[ch] != PS_CODE_STOP);
        end
    end

    always_ff @(posedge XCLK_I) begin
        if (RST) begin
            sync_q      <= '0;
            hist_q      <= 1'b0;
            busy_q      <= 1'b0;
            ack_q       <= 1'b0;
            cap_ch_q    <= 2'd0;
            cap_ps_q    <= PS_CODE_STOP;
            ps_active_q <= '0;
            for (int ch = 0; ch < int'(NCH); ch++) begin
                code_q[ch] <= PS_CODE_STOP;
            end
        end else begin
            sync_q      <= {sync_q[SYNC_FF-2:0], CTRL_REQ};
            hist_q      <= sync_q[SYNC_FF-1];
            busy_q      <= busy_d;
            ack_q       <= ack_d;
            cap_ch_q    <= cap_ch_d;
            cap_ps_q    <= cap_ps_d;
            ps_active_q <= ps_active_d;
            code_q      <= code_d;
        end
    end

    for (genvar g = 0; g < int'(NCH); g++) begin : g_chan
        mfp_prescaler_chan u_chan (
            .clk_i  (XCLK_I),
            .rst_i  (RST),
            .code_i (code_q[g]),
            .tick_o (TICK_O[g])
        );
    end

    assign CTRL_ACK  = ack_q;
    assign BUSY      = busy_q;
    assign PS_ACTIVE = ps_active_q;

endmodule

// File: tb/tb_mfp_prescaler_sched.sv
// Directed bench for mfp_prescaler_sched: handshake latency, tick periods,
// code-change corner cases, channel isolation, protocol misuse and reset abort.
module tb_mfp_prescaler_sched;

    logic       XCLK_I;
    logic       RST;
    logic       CTRL_REQ;
    logic [1:0] CTRL_CH;
    logic [2:0] CTRL_PS;
    logic       CTRL_ACK;
    logic [3:0] TICK_O;
    logic [3:0] PS_ACTIVE;
    logic       BUSY;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int viol  = 0;
    int ack_chg = 0;

    // Interval monitor state
    logic [3:0] mon_en   = '0;
    int         mon_exp [4];
    int         last_flip [4];
    logic [3:0] last_ok  = '0;
    int         mon_hits [4];
    logic [3:0] tick_prev = '0;

    mfp_prescaler_sched #(
        .NCH     (4),
        .SYNC_FF (2)
    ) u_dut (
        .XCLK_I    (XCLK_I),
        .RST       (RST),
        .CTRL_REQ  (CTRL_REQ),
        .CTRL_CH   (CTRL_CH),
        .CTRL_PS   (CTRL_PS),
        .CTRL_ACK  (CTRL_ACK),
        .TICK_O    (TICK_O),
        .PS_ACTIVE (PS_ACTIVE),
        .BUSY      (BUSY)
    );

    initial begin
        XCLK_I = 1'b0;
        forever #5 XCLK_I = ~XCLK_I;
    end

    initial forever begin
        @(posedge XCLK_I);
        cyc++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    initial forever begin
        @(negedge XCLK_I);
        for (int c = 0; c < 4; c++) begin
            if (!mon_en[c]) begin
                last_ok[c] = 1'b0;
            end else if (TICK_O[c] != tick_prev[c]) begin
                if (last_ok[c]) begin
                    check($sformatf("interval ch%0d", c), cyc - last_flip[c], mon_exp[c]);
                    mon_hits[c]++;
                end
                last_ok[c]   = 1'b1;
                last_flip[c] = cyc;
            end
            tick_prev[c] = TICK_O[c];
        end
    end

    initial forever begin
        @(CTRL_REQ);
        if (BUSY === 1'b1 && RST === 1'b0) viol++;
    end

    initial forever begin
        @(CTRL_ACK);
        ack_chg++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Starts and ends just after a falling edge; lat counts cycles until ACK == REQ.
    task automatic do_req(input int ch, input int ps, output int lat);
        CTRL_CH  = 2'(ch);
        CTRL_PS  = 3'(ps);
        CTRL_REQ = ~CTRL_REQ;
        lat = 0;
        while (CTRL_ACK != CTRL_REQ && lat < 20) begin
            @(negedge XCLK_I);
            lat++;
        end
    endtask

    task automatic measure(input int ch, input int bound, output int n);
        logic p;
        p = TICK_O[ch];
        n = 0;
        do begin
            @(negedge XCLK_I);
            n++;
        end while (TICK_O[ch] == p && n <= bound);
    endtask

    logic [2:0] hammer [20] = '{3'd1, 3'd7, 3'd2, 3'd0, 3'd3, 3'd6, 3'd5, 3'd4, 3'd1, 3'd0,
                                3'd7, 3'd7, 3'd2, 3'd3, 3'd0, 3'd6, 3'd1, 3'd5, 3'd4, 3'd0};

    initial begin
        int   lat, n, k, k2, snap;
        logic lvl;

        RST = 1'b1; CTRL_REQ = 1'b0; CTRL_CH = 2'd0; CTRL_PS = 3'd0;
        mon_exp[0] = 4; mon_exp[1] = 0; mon_exp[2] = 0; mon_exp[3] = 64;
        for (int c = 0; c < 4; c++) begin
            last_flip[c] = 0;
            mon_hits[c]  = 0;
        end
        repeat (4) @(negedge XCLK_I);
        RST = 1'b0;
        check("reset ack", int'(CTRL_ACK), 0);
        check("reset busy", int'(BUSY), 0);
        check("reset tick", int'(TICK_O), 0);
        check("reset active", int'(PS_ACTIVE), 0);

        // 1: ch0 code 1
        do_req(0, 1, lat);
        check("t1 ack latency", lat, 4);
        check("t1 active", int'(PS_ACTIVE), 4'b0001);
        measure(0, 50, n); check("t1 first flip", n, 4);
        measure(0, 50, n); check("t1 period", n, 4);
        check("t1 other ticks", int'(TICK_O[3:1]), 0);

        // 3: ch1 code 3, stop, then code 2
        do_req(1, 3, lat);
        check("t3 ack latency", lat, 4);
        measure(1, 50, n); check("t3 code3 first flip", n, 16);
        repeat (5) @(negedge XCLK_I);
        do_req(1, 0, lat);
        check("t3 stop latency", lat, 4);
        lvl = TICK_O[1];
        check("t3 ch1 inactive", int'(PS_ACTIVE[1]), 0);
        repeat (40) @(negedge XCLK_I);
        check("t3 tick frozen", int'(TICK_O[1]), int'(lvl));
        do_req(1, 2, lat);
        measure(1, 50, n); check("t3 code2 first flip", n, 10);
        measure(1, 50, n); check("t3 code2 period", n, 10);

        // 2: ch2 code 7 to cnt 150, then code 1
        do_req(2, 7, lat);
        check("t2 ack latency", lat, 4);
        repeat (147) @(negedge XCLK_I);
        do_req(2, 1, lat);
        check("t2 shrink latency", lat, 4);
        measure(2, 250, n); check("t2 flip at 199", n, 49);
        measure(2, 50, n); check("t2 period after", n, 4);

        // 4: isolation while ch1 is hammered
        do_req(3, 5, lat);
        mon_en = 4'b1001;
        for (int i = 0; i < 20; i++) begin
            do_req(1, int'(hammer[i]), lat);
            check($sformatf("t4 hammer latency %0d", i), lat, 4);
            repeat (i % 3) @(negedge XCLK_I);
        end
        repeat (200) @(negedge XCLK_I);
        mon_en = 4'b0000;
        check("t4 ch3 intervals seen", int'(mon_hits[3] >= 3), 1);
        check("t4 ch0 intervals seen", int'(mon_hits[0] >= 40), 1);

        // 5: double REQ toggle while BUSY
        snap = ack_chg;
        CTRL_CH = 2'd2; CTRL_PS = 3'd3;
        CTRL_REQ = ~CTRL_REQ;
        k = 0;
        while (BUSY !== 1'b1 && k < 10) begin
            @(negedge XCLK_I);
            k++;
        end
        check("t5 busy after", k, 3);
        CTRL_CH = 2'd1; CTRL_PS = 3'd6;
        CTRL_REQ = ~CTRL_REQ;
        #1 CTRL_REQ = ~CTRL_REQ;
        k2 = 0;
        while (CTRL_ACK != CTRL_REQ && k2 < 20) begin
            @(negedge XCLK_I);
            k2++;
        end
        check("t5 ack latency", k + k2, 4);
        repeat (10) @(negedge XCLK_I);
        check("t5 single ack", ack_chg - snap, 1);
        check("t5 violations", viol, 2);
        check("t5 active", int'(PS_ACTIVE), 4'b1101);
        measure(2, 50, n); check("t5 ch2 first bounded", int'(n <= 16), 1);
        measure(2, 50, n); check("t5 ch2 period", n, 16);

        // 6: reset one cycle after a request
        CTRL_CH = 2'd0; CTRL_PS = 3'd4;
        CTRL_REQ = ~CTRL_REQ;
        @(negedge XCLK_I);
        RST = 1'b1;
        CTRL_REQ = 1'b0;
        repeat (3) @(negedge XCLK_I);
        RST = 1'b0;
        check("t6 ack", int'(CTRL_ACK), 0);
        check("t6 busy", int'(BUSY), 0);
        check("t6 active", int'(PS_ACTIVE), 0);
        check("t6 tick", int'(TICK_O), 0);
        repeat (250) @(negedge XCLK_I);
        check("t6 tick idle", int'(TICK_O), 0);
        check("t6 ack idle", int'(CTRL_ACK), 0);
        check("t6 busy idle", int'(BUSY), 0);
        do_req(0, 1, lat);
        check("t6 relaunch latency", lat, 4);
        measure(0, 50, n); check("t6 relaunch flip", n, 4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
